axi_soc_master: RTL and testbench
=================================

AXI_SOC_MASTER -- requirements
Module: axi_soc_master

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter TIMEOUT, default 255, max wait cycles per channel phase; legal range 1..65535.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rstn  input  1  reset; synchronous, active-low.
REQ-006 cmd_valid/cmd_ready  input/output  1/1  request handshake from CPU side.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_addr  input  ADDR_W  target address.
REQ-009 cmd_wdata  input  DATA_W  write payload.
REQ-010 cmd_opcode  input  2  operation code forwarded to the slave.
REQ-011 rsp_valid/rsp_ready  output/input  1/1  completion handshake to CPU side.
REQ-012 rsp_rdata  output  DATA_W  read data (0 for writes).
REQ-013 rsp_err  output  1  transaction aborted by timeout.
REQ-014 write_addr, write_addr_valid / write_addr_ready  output ADDR_W,1 / input 1  AW channel.
REQ-015 write_data, write_data_valid / write_data_ready  output DATA_W,1 / input 1  W channel.
REQ-016 read_addr, read_addr_valid / read_addr_ready  output ADDR_W,1 / input 1  AR channel.
REQ-017 read_data, read_data_valid / read_data_ready  input DATA_W,1 / output 1  R channel.
REQ-018 opcode  output  2  registered cmd_opcode, stable from acceptance until the next accepted command.

Function
REQ-019 States: IDLE, WRITE, RD_ADDR, RD_DATA, RESP.
REQ-020 cmd_ready = 1 only in IDLE; a command is accepted on a cycle with cmd_valid & cmd_ready; addr/wdata/opcode/write are registered at acceptance.
REQ-021 IDLE -> WRITE (cmd_write=1) or RD_ADDR (cmd_write=0) on acceptance; write_addr_valid and write_data_valid (or read_addr_valid) assert in the very next cycle.
REQ-022 WRITE: AW and W are presented concurrently; each valid drops the cycle after its own handshake (valid & ready); the state moves to RESP once both handshakes are done, including when both occur in the same cycle.
REQ-023 A valid, once asserted, stays high with stable address/data until its handshake; it never de-asserts for any reason other than handshake, timeout, or reset.
REQ-024 RD_ADDR: on read_addr_valid & read_addr_ready -> RD_DATA; read_data_ready is 1 only in RD_DATA.
REQ-025 RD_DATA: on read_data_valid & read_data_ready, capture read_data into rsp_rdata -> RESP.
REQ-026 RESP: rsp_valid = 1 holding rsp_rdata/rsp_err stable; on rsp_ready -> IDLE; a new command is not accepted in the same cycle (minimum one IDLE cycle).
REQ-027 Minimum latency with always-ready slave: write acceptance to rsp_valid = 2 cycles; read = 3 cycles.
REQ-028 Timeout counter clears on every state entry and increments each cycle in WRITE/RD_ADDR/RD_DATA; reaching TIMEOUT drops all channel valids/read_data_ready, sets rsp_err=1, rsp_rdata=0 -> RESP.
REQ-029 A handshake in the same cycle the counter reaches TIMEOUT takes priority; no error is raised.
REQ-030 Counter width = $clog2(TIMEOUT+1); it saturates and never wraps.
REQ-031 rsp_err clears when a new command is accepted.

Reset
REQ-032 While rstn=0 at a clock edge: state=IDLE, all valids/read_data_ready/rsp_valid/rsp_err=0, rsp_rdata/write_addr/write_data/read_addr=0, opcode=0, counter=0.
REQ-033 Reset mid-transaction abandons it without a response; cmd_ready=1 in the first cycle after rstn returns high.

Structure
REQ-034 Package axi_soc_pkg holds the state enum, the opcode typedef (2-bit), and the default width/timeout constants.
REQ-035 One sub-module axi_soc_timeout (clear, enable, expired output, TIMEOUT parameter); all else in axi_soc_master.

Verification
REQ-036 Write 0x10/0xDEADBEEF, slave always ready -> AW and W handshakes in cycle 1, rsp_valid in cycle 2, rsp_err=0.
REQ-037 Write with AW ready at cycle 1 and W ready at cycle 4 -> write_addr_valid drops after cycle 1, write_data_valid held to 4, rsp_valid in cycle 5.
REQ-038 Read 0x20, AR ready at cycle 1, R valid with 0xCAFEF00D at cycle 3 -> rsp_rdata=0xCAFEF00D, rsp_valid in cycle 4.
REQ-039 TIMEOUT=4, read_addr_ready held at 0 -> read_addr_valid drops and rsp_valid=1, rsp_err=1, rsp_rdata=0 after 4 waiting cycles.
REQ-040 rsp_ready held low for 3 cycles in RESP -> rsp_* stable, cmd_ready=0 throughout; after release, a back-to-back command is accepted one cycle later.
REQ-041 rstn pulsed low during RD_DATA -> all outputs at reset values next edge, no rsp_valid, next read completes normally.

Source files
------------

// File: rtl/axi_soc_pkg.sv
// axi_soc_pkg
//   Shared types and default constants for the AXI-style SoC master.
//   - state_t  : controller states (also exported on the debug port)
//   - opcode_t : 2-bit operation code forwarded to the slave
//   - DEF_*    : default address/data widths and phase timeout
package axi_soc_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_RD_ADDR = 3'd2,
        S_RD_DATA = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    typedef logic [1:0] opcode_t;

endpackage

// File: rtl/axi_soc_if.sv
// axi_soc_if
//   Bundles the CPU-side command/response handshakes and the AW/W/AR/R
//   slave channels of the SoC master.
//   Modports:
//     master : view of axi_soc_master (drives cmd_ready, rsp_*, channel
//              valids/payloads, read_data_ready, opcode)
//     slave  : view of the environment (CPU + memory slave)
//
// Handshake rule for every valid/ready pair below: a transfer happens on a
// rising clock edge where both valid and ready are 1. Once valid is raised
// its payload is held stable and valid stays high until that transfer
// (or a timeout/reset abandons it). ready may change freely and is allowed
// to be high before valid.
interface axi_soc_if
    import axi_soc_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    // CPU command
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    opcode_t           cmd_opcode;

    // CPU response
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    // AW channel
    logic [ADDR_W-1:0] write_addr;
    logic              write_addr_valid;
    logic              write_addr_ready;

    // W channel
    logic [DATA_W-1:0] write_data;
    logic              write_data_valid;
    logic              write_data_ready;

    // AR channel
    logic [ADDR_W-1:0] read_addr;
    logic              read_addr_valid;
    logic              read_addr_ready;

    // R channel
    logic [DATA_W-1:0] read_data;
    logic              read_data_valid;
    logic              read_data_ready;

    // Opcode of the most recently accepted command
    opcode_t           opcode;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_opcode,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output write_addr, write_addr_valid,
        input  write_addr_ready,
        output write_data, write_data_valid,
        input  write_data_ready,
        output read_addr, read_addr_valid,
        input  read_addr_ready,
        input  read_data, read_data_valid,
        output read_data_ready,
        output opcode
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_opcode,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  write_addr, write_addr_valid,
        output write_addr_ready,
        input  write_data, write_data_valid,
        output write_data_ready,
        input  read_addr, read_addr_valid,
        output read_addr_ready,
        output read_data, read_data_valid,
        input  read_data_ready,
        input  opcode
    );

endinterface

// File: rtl/axi_soc_timeout.sv
// axi_soc_timeout
//   Per-phase wait counter. Counts cycles while enable is high and flags
//   the cycle in which the count would reach TIMEOUT.
//   Ports:
//     clk, rstn : clock, synchronous active-low reset
//     clear     : zero the count (wins over enable)
//     enable    : a channel phase is waiting this cycle
//     expired   : this is the TIMEOUT-th waiting cycle of the phase
module axi_soc_timeout
    import axi_soc_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Saturates at TIMEOUT so a stalled enable can never wrap back to zero.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    // The count starts at 0 on phase entry, so the TIMEOUT-th waiting cycle
    // is the one where the count holds TIMEOUT-1 and would step to TIMEOUT.
    assign expired = enable && (count == CNT_LAST);

endmodule

// File: rtl/axi_soc_master.sv
// axi_soc_master
//   Turns single CPU read/write commands into AW+W or AR+R channel
//   transactions and returns one response per command. Each waiting phase
//   is bounded by TIMEOUT cycles; on expiry the phase is abandoned and an
//   error response is returned.
//   Ports:
//     clk, rstn : clock, synchronous active-low reset
//     bus       : axi_soc_if master modport (command, response, channels)
//     dbg_state : current controller state
module axi_soc_master
    import axi_soc_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic       clk,
    input  logic       rstn,
    axi_soc_if.master  bus,
    output state_t     dbg_state
);

    state_t state;
    logic   tmo_clear;
    logic   tmo_en;
    logic   tmo_expired;
    logic   aw_done;
    logic   w_done;

    assign dbg_state     = state;
    assign bus.cmd_ready = (state == S_IDLE);

    // A channel counts as done if its handshake already happened (valid
    // dropped) or is happening in this cycle.
    assign aw_done = !bus.write_addr_valid || bus.write_addr_ready;
    assign w_done  = !bus.write_data_valid || bus.write_data_ready;

    assign tmo_en = (state == S_WRITE) || (state == S_RD_ADDR) ||
                    (state == S_RD_DATA);
    // Outside the waiting states the counter is held at zero; the AR->R
    // hand-over also restarts it so RD_DATA gets its own full budget.
    assign tmo_clear = !tmo_en ||
        ((state == S_RD_ADDR) && bus.read_addr_valid && bus.read_addr_ready);

    axi_soc_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (tmo_clear),
        .enable  (tmo_en),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state                <= S_IDLE;
            bus.write_addr_valid <= 1'b0;
            bus.write_data_valid <= 1'b0;
            bus.read_addr_valid  <= 1'b0;
            bus.read_data_ready  <= 1'b0;
            bus.rsp_valid        <= 1'b0;
            bus.rsp_err          <= 1'b0;
            bus.rsp_rdata        <= {DATA_W{1'b0}};
            bus.write_addr       <= {ADDR_W{1'b0}};
            bus.write_data       <= {DATA_W{1'b0}};
            bus.read_addr        <= {ADDR_W{1'b0}};
            bus.opcode           <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.opcode    <= bus.cmd_opcode;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rdata <= {DATA_W{1'b0}};
                        if (bus.cmd_write) begin
                            bus.write_addr       <= bus.cmd_addr;
                            bus.write_data       <= bus.cmd_wdata;
                            bus.write_addr_valid <= 1'b1;
                            bus.write_data_valid <= 1'b1;
                            state                <= S_WRITE;
                        end else begin
                            bus.read_addr       <= bus.cmd_addr;
                            bus.read_addr_valid <= 1'b1;
                            state               <= S_RD_ADDR;
                        end
                    end
                end

                S_WRITE: begin
                    if (bus.write_addr_valid && bus.write_addr_ready)
                        bus.write_addr_valid <= 1'b0;
                    if (bus.write_data_valid && bus.write_data_ready)
                        bus.write_data_valid <= 1'b0;
                    // Completion is checked first so a handshake landing on
                    // the expiry cycle still counts as success.
                    if (aw_done && w_done) begin
                        bus.rsp_valid <= 1'b1;
                        state         <= S_RESP;
                    end else if (tmo_expired) begin
                        bus.write_addr_valid <= 1'b0;
                        bus.write_data_valid <= 1'b0;
                        bus.rsp_err          <= 1'b1;
                        bus.rsp_rdata        <= {DATA_W{1'b0}};
                        bus.rsp_valid        <= 1'b1;
                        state                <= S_RESP;
                    end
                end

                S_RD_ADDR: begin
                    if (bus.read_addr_valid && bus.read_addr_ready) begin
                        bus.read_addr_valid <= 1'b0;
                        bus.read_data_ready <= 1'b1;
                        state               <= S_RD_DATA;
                    end else if (tmo_expired) begin
                        bus.read_addr_valid <= 1'b0;
                        bus.rsp_err         <= 1'b1;
                        bus.rsp_rdata       <= {DATA_W{1'b0}};
                        bus.rsp_valid       <= 1'b1;
                        state               <= S_RESP;
                    end
                end

                S_RD_DATA: begin
                    if (bus.read_data_valid) begin
                        bus.rsp_rdata       <= bus.read_data;
                        bus.read_data_ready <= 1'b0;
                        bus.rsp_valid       <= 1'b1;
                        state               <= S_RESP;
                    end else if (tmo_expired) begin
                        bus.read_data_ready <= 1'b0;
                        bus.rsp_err         <= 1'b1;
                        bus.rsp_rdata       <= {DATA_W{1'b0}};
                        bus.rsp_valid       <= 1'b1;
                        state               <= S_RESP;
                    end
                end

                S_RESP: begin
                    // Returning to IDLE guarantees at least one cycle with
                    // cmd_ready high before the next command is taken.
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_soc_master.sv
// tb_axi_soc_master
//   Scripted slave/CPU driver with a per-transaction timeline model, a
//   per-cycle compare process, a response scoreboard and literal latency
//   checks for the directed scenarios.
module tb_axi_soc_master;
    import axi_soc_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 4;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    axi_soc_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    state_t dbg_state;

    axi_soc_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- model types ----------------
    typedef struct {
        bit            write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic [1:0]    op;
        int            d1;   // AW/AR ready delay
        int            d2;   // W ready delay or R valid delay
        int            drr;  // rsp_ready delay
        int            gap;  // idle cycles before the command
    } txn_t;

    typedef struct {
        int rsp_c;
        bit err;
        int aw_last, w_last, ar_last, rd_s, rd_last;
    } plan_t;

    typedef struct {
        bit            cmd_ready, aw_v, w_v, ar_v, r_rdy, rsp_v, rsp_err, zero_all;
        logic [DW-1:0] rsp_rdata, w_data;
        logic [AW-1:0] aw_addr, ar_addr;
        logic [1:0]    opcode;
        int            txn, k;
    } exp_t;

    // ---------------- scoreboard state ----------------
    int            tests = 0;
    int            fails = 0;
    exp_t          e;
    bit            exp_on = 1'b0;
    logic [DW:0]   exp_q[$];
    logic [DW:0]   got;
    int            obs_lat = -1;
    int            lat_txn = -1;
    bit            last_err = 1'b0;
    logic [1:0]    last_op = 2'd0;
    int            cur_txn = 0;
    txn_t          rq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s txn=%0d cycle=%0d: got %0h, expected %0h",
                     name, e.txn, e.k, act, expv);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Cycle 0 = acceptance cycle; a ready delay d means ready from cycle 1+d.
    // A phase waits at most T cycles; a handshake on the T-th still counts.
    function automatic plan_t plan(input txn_t t);
        plan_t p;
        p = '{default: 0};
        if (t.write) begin
            p.aw_last = imin(1 + t.d1, T);
            p.w_last  = imin(1 + t.d2, T);
            p.err     = (t.d1 > T - 1) || (t.d2 > T - 1);
            p.rsp_c   = p.err ? T + 1 : 2 + ((t.d1 > t.d2) ? t.d1 : t.d2);
        end else begin
            p.ar_last = imin(1 + t.d1, T);
            if (t.d1 > T - 1) begin
                p.err   = 1'b1;
                p.rsp_c = T + 1;
            end else begin
                p.rd_s = 2 + t.d1;
                if (t.d2 > T - 1) begin
                    p.err     = 1'b1;
                    p.rd_last = p.rd_s + T - 1;
                    p.rsp_c   = p.rd_s + T;
                end else begin
                    p.rd_last = p.rd_s + t.d2;
                    p.rsp_c   = p.rd_last + 1;
                end
            end
        end
        return p;
    endfunction

    function automatic exp_t idle_exp(input int k);
        exp_t x;
        x = '{default: 0};
        x.cmd_ready = 1'b1;
        x.rsp_err   = last_err;
        x.opcode    = last_op;
        x.txn       = cur_txn;
        x.k         = k;
        return x;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (exp_on) begin
            chk("cmd_ready",        64'(bus.cmd_ready),        64'(e.cmd_ready));
            chk("write_addr_valid", 64'(bus.write_addr_valid), 64'(e.aw_v));
            chk("write_data_valid", 64'(bus.write_data_valid), 64'(e.w_v));
            chk("read_addr_valid",  64'(bus.read_addr_valid),  64'(e.ar_v));
            chk("read_data_ready",  64'(bus.read_data_ready),  64'(e.r_rdy));
            chk("rsp_valid",        64'(bus.rsp_valid),        64'(e.rsp_v));
            chk("rsp_err",          64'(bus.rsp_err),          64'(e.rsp_err));
            chk("opcode",           64'(bus.opcode),           64'(e.opcode));
            if (e.aw_v)  chk("write_addr", 64'(bus.write_addr), 64'(e.aw_addr));
            if (e.w_v)   chk("write_data", 64'(bus.write_data), 64'(e.w_data));
            if (e.ar_v)  chk("read_addr",  64'(bus.read_addr),  64'(e.ar_addr));
            if (e.rsp_v) chk("rsp_rdata",  64'(bus.rsp_rdata),  64'(e.rsp_rdata));
            if (e.zero_all) begin
                chk("rst_write_addr", 64'(bus.write_addr), 64'(0));
                chk("rst_write_data", 64'(bus.write_data), 64'(0));
                chk("rst_read_addr",  64'(bus.read_addr),  64'(0));
                chk("rst_rsp_rdata",  64'(bus.rsp_rdata),  64'(0));
                chk("rst_state",      64'(dbg_state),      64'(S_IDLE));
            end
            if (bus.rsp_valid === 1'b1 && e.k >= 1 && lat_txn != e.txn) begin
                obs_lat = e.k;
                lat_txn = e.txn;
            end
            if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
                got = {bus.rsp_err, bus.rsp_rdata};
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL scoreboard txn=%0d: unexpected response %0h, expected none",
                             e.txn, got);
                end else begin
                    chk("scoreboard", 64'(got), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input exp_t x);
        @(posedge clk);
        #1;
        e      = x;
        exp_on = 1'b1;
    endtask

    task automatic drive_idle();
        bus.cmd_valid        = 1'b0;
        bus.cmd_write        = 1'($urandom_range(0, 1));
        bus.cmd_addr         = AW'($urandom);
        bus.cmd_wdata        = DW'($urandom);
        bus.cmd_opcode       = 2'($urandom_range(0, 3));
        bus.write_addr_ready = 1'b0;
        bus.write_data_ready = 1'b0;
        bus.read_addr_ready  = 1'b0;
        bus.read_data_valid  = 1'b0;
        bus.read_data        = DW'($urandom);
        bus.rsp_ready        = 1'b0;
    endtask

    task automatic drive_cmd(input txn_t t);
        bus.cmd_valid  = 1'b1;
        bus.cmd_write  = t.write;
        bus.cmd_addr   = t.addr;
        bus.cmd_wdata  = t.wdata;
        bus.cmd_opcode = t.op;
    endtask

    // Runs one transaction cycle by cycle. b2b: present nt during this
    // transaction's response handshake cycle. abort_k: pulse reset in that
    // cycle and abandon the transaction.
    task automatic run_txn(input txn_t t, input bit b2b, input txn_t nt, input int abort_k);
        plan_t         p;
        exp_t          x;
        int            h;
        bit            rv;
        logic [DW-1:0] rd;
        p  = plan(t);
        h  = p.rsp_c + t.drr;
        rd = (p.err || t.write) ? '0 : t.rdata;
        cur_txn++;
        if (abort_k == 0) exp_q.push_back({p.err, rd});
        for (int g = 0; g < t.gap; g++) begin
            step(idle_exp(-1));
            drive_idle();
        end
        step(idle_exp(0));
        drive_idle();
        drive_cmd(t);
        for (int k = 1; k <= h; k++) begin
            x = '{default: 0};
            x.aw_v      = t.write && (k <= p.aw_last);
            x.w_v       = t.write && (k <= p.w_last);
            x.ar_v      = !t.write && (k <= p.ar_last);
            x.r_rdy     = !t.write && (p.rd_s != 0) && (k >= p.rd_s) && (k <= p.rd_last);
            x.rsp_v     = (k >= p.rsp_c);
            x.rsp_err   = x.rsp_v && p.err;
            x.rsp_rdata = rd;
            x.aw_addr   = t.addr;
            x.w_data    = t.wdata;
            x.ar_addr   = t.addr;
            x.opcode    = t.op;
            x.txn       = cur_txn;
            x.k         = k;
            step(x);
            drive_idle();
            bus.write_addr_ready = t.write && (k >= 1 + t.d1);
            bus.write_data_ready = t.write && (k >= 1 + t.d2);
            bus.read_addr_ready  = !t.write && (k >= 1 + t.d1);
            rv = !t.write && (p.rd_s != 0) && (k >= p.rd_s + t.d2);
            bus.read_data_valid  = rv;
            if (rv) bus.read_data = t.rdata;
            bus.rsp_ready        = (k >= p.rsp_c + t.drr);
            if (k == h && b2b) drive_cmd(nt);
            if (k == abort_k) begin
                rstn = 1'b0;
                break;
            end
        end
        if (abort_k != 0) begin
            last_err   = 1'b0;
            last_op    = 2'd0;
            x          = idle_exp(-1);
            x.zero_all = 1'b1;
            step(x);
            rstn = 1'b1;
            drive_idle();
        end else begin
            last_err = p.err;
            last_op  = t.op;
        end
    endtask

    task automatic check_lat(input string name, input int want);
        @(negedge clk);
        #1;
        chk(name, 64'((lat_txn == cur_txn) ? obs_lat : -1), 64'(want));
    endtask

    function automatic txn_t mk(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                input logic [DW-1:0] rdv, input int d1, input int d2,
                                input int drr, input int gap);
        txn_t t;
        t.write = w;  t.addr = a;   t.wdata = wd; t.rdata = rdv;
        t.op    = 2'($urandom_range(0, 3));
        t.d1    = d1; t.d2 = d2; t.drr = drr; t.gap = gap;
        return t;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        exp_t x;
        txn_t nt, dummy;
        drive_idle();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        x          = idle_exp(-1);
        x.zero_all = 1'b1;
        step(x);
        rstn = 1'b1;

        dummy = mk(1'b0, 0, 0, 0, 0, 0, 0, 1);

        // Always-ready write
        run_txn(mk(1'b1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 1), 1'b0, dummy, 0);
        check_lat("lat_write_fast", 2);
        // AW ready at cycle 1, W ready at cycle 4 (last legal cycle)
        run_txn(mk(1'b1, 32'h44, 32'h12345678, 0, 0, 3, 1, 1), 1'b0, dummy, 0);
        check_lat("lat_write_w_late", 5);
        // AR ready at cycle 1, R valid at cycle 3
        run_txn(mk(1'b0, 32'h20, 0, 32'hCAFEF00D, 0, 1, 0, 1), 1'b0, dummy, 0);
        check_lat("lat_read_r_late", 4);
        // AR never ready -> timeout
        run_txn(mk(1'b0, 32'h30, 0, 32'h55AA55AA, 9, 0, 1, 2), 1'b0, dummy, 0);
        check_lat("lat_read_timeout", 5);
        // Response held 3 cycles, next command presented back-to-back
        nt = mk(1'b0, 32'h80, 0, 32'h0BADF00D, 0, 0, 0, 0);
        run_txn(mk(1'b1, 32'h70, 32'hA5A5A5A5, 0, 0, 0, 3, 1), 1'b1, nt, 0);
        check_lat("lat_write_hold", 2);
        run_txn(nt, 1'b0, dummy, 0);
        check_lat("lat_read_fast", 3);
        // Reset during RD_DATA, then a normal read
        run_txn(mk(1'b0, 32'h90, 0, 32'h11112222, 0, 9, 0, 1), 1'b0, dummy, 3);
        run_txn(mk(1'b0, 32'h94, 0, 32'h33334444, 0, 0, 0, 0), 1'b0, dummy, 0);
        check_lat("lat_read_after_reset", 3);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            rq.push_back(mk(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                            DW'($urandom), $urandom_range(0, 5), $urandom_range(0, 5),
                            $urandom_range(0, 3), $urandom_range(0, 2)));
        end
        for (int i = 0; i < rq.size(); i++) begin
            if (i + 1 < rq.size())
                run_txn(rq[i], rq[i + 1].gap == 0, rq[i + 1], 0);
            else
                run_txn(rq[i], 1'b0, dummy, 0);
        end

        step(idle_exp(-1));
        drive_idle();
        step(idle_exp(-1));
        @(negedge clk);
        #1;
        exp_on = 1'b0;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
